// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_scheduler
// Purpose  : Two requesters share one iterative double-dabble engine that
//            converts an N-bit binary operand into three BCD digits.
//            Round-robin arbitration uses a last-served flag.
// Ports    : clock         - single clock, rising edge
//            reset         - synchronous, active-high
//            req0/req1     - level requests, held until the matching ack
//            bin0/bin1     - N-bit operands, sampled only on the grant edge
//            ack0/ack1     - one-cycle result-valid pulses (never together)
//            bcd0/bcd1     - 12-bit results {hundreds, tens, units}, held
//            busy          - high while a conversion is in progress
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_scheduler #(
  parameter int N = 8  // operand width, 1..9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] bin0,
  input  logic         req1,
  input  logic [N-1:0] bin1,
  output logic         ack0,
  output logic         ack1,
  output logic [11:0]  bcd0,
  output logic [11:0]  bcd1,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [11:0]     bcd_q;    // shared BCD shift register
  logic [N-1:0]    opnd_q;   // shared operand register
  logic [CW-1:0]   cnt_q;    // shift counter
  logic            sel_q;    // requester currently being served
  logic            last_q;   // last-served requester (1 = requester 1)
  logic [11:0]     bcd0_q;
  logic [11:0]     bcd1_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            busy_q;

  logic [11:0]     adj_d;    // digits after the add-3 correction
  logic [11:0]     shift_d;  // BCD value after this cycle's shift
  logic            grant1_d; // 1 = grant requester 1 this cycle

  // Add-3 correction on every digit >= 5, then shift in the operand MSB.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shift_d = {adj_d[10:0], opnd_q[N-1]};
  end

  // Requester 1 wins when it is alone, or on a tie when requester 0
  // was the one served last.
  always_comb begin
    grant1_d = req1 & (~req0 | ~last_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcd_q   <= 12'h000;
      opnd_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      bcd0_q  <= 12'h000;
      bcd1_q  <= 12'h000;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 | req1) begin
            sel_q   <= grant1_d;
            last_q  <= grant1_d;
            opnd_q  <= grant1_d ? bin1 : bin0;
            bcd_q   <= 12'h000;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q  <= shift_d;
          opnd_q <= opnd_q << 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            // Publish the result now so it is stable before the ack pulse.
            if (sel_q) begin
              bcd1_q <= shift_d;
            end else begin
              bcd0_q <= shift_d;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // The ack register is loaded on the edge leaving DONE, so the
          // pulse appears N+1 edges after the grant edge.
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign bcd0 = bcd0_q;
  assign bcd1 = bcd1_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_scheduler
// Purpose  : Self-checking bench for bcd_convert_scheduler. Expected results
//            come from decimal arithmetic and an arbitration model that only
//            tracks which requester was served last.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_scheduler;

  localparam int N  = 8;
  localparam int N9 = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  bin0, bin1;
  logic        ack0, ack1, busy;
  logic [11:0] bcd0, bcd1;

  logic        req9;
  logic [8:0]  bin9;
  logic        ack9_0, ack9_1, busy9;
  logic [11:0] bcd9_0, bcd9_1;

  int checks   = 0;
  int failures = 0;

  bit          last_m;     // model: last-served requester
  logic [11:0] bcd_m [2];  // model: held result registers

  always #5 clock = ~clock;

  bcd_convert_scheduler #(.N(N)) u_dut (
    .clock (clock), .reset (reset),
    .req0  (req0),  .bin0  (bin0),
    .req1  (req1),  .bin1  (bin1),
    .ack0  (ack0),  .ack1  (ack1),
    .bcd0  (bcd0),  .bcd1  (bcd1),
    .busy  (busy)
  );

  bcd_convert_scheduler #(.N(N9)) u_dut9 (
    .clock (clock),  .reset (reset),
    .req0  (req9),   .bin0  (bin9),
    .req1  (1'b0),   .bin1  (9'd0),
    .ack0  (ack9_0), .ack1  (ack9_1),
    .bcd0  (bcd9_0), .bcd1  (bcd9_1),
    .busy  (busy9)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for requester id's ack, overwriting its operand after the grant.
  task automatic serve(input int id, input logic [7:0] scr, input string tag);
    int cyc = 0;
    bit got = 0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (id == 0) bin0 = scr; else bin1 = scr;
      if (cyc == 1) chk({tag, "_busy_on"}, 32'(busy), 32'd1);
      if (ack0 | ack1) got = 1;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(N + 2));
    chk({tag, "_ack"}, {30'd0, ack1, ack0}, (id == 1) ? 32'd2 : 32'd1);
    chk({tag, "_bcd0"}, 32'(bcd0), 32'(bcd_m[0]));
    chk({tag, "_bcd1"}, 32'(bcd1), 32'(bcd_m[1]));
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    last_m = (id == 1);
  endtask

  task automatic transact(input bit r0, input bit r1, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] s0,
                          input logic [7:0] s1, input string tag);
    int first;
    @(negedge clock);
    req0 = r0; req1 = r1; bin0 = b0; bin1 = b1;
    if (r0 && r1) first = last_m ? 0 : 1;
    else          first = r0 ? 0 : 1;
    bcd_m[first] = to_bcd(first == 1 ? int'(b1) : int'(b0));
    serve(first, first == 1 ? s1 : s0, {tag, "_a"});
    if (r0 && r1) begin
      bcd_m[1-first] = to_bcd(first == 1 ? int'(b0) : int'(b1));
      serve(1 - first, first == 1 ? s0 : s1, {tag, "_b"});
    end
    @(negedge clock);
    chk({tag, "_pulse_end"}, {30'd0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    int cyc, n, prev, exp_id, collide, seen, val;
    bit ok;
    logic [7:0] a, b;

    // Reset for two edges, then idle with no requests.
    reset = 1'b1; req0 = 0; req1 = 0; bin0 = 0; bin1 = 0; req9 = 0; bin9 = 0;
    last_m = 1'b1; bcd_m[0] = 12'h000; bcd_m[1] = 12'h000;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_outputs", {3'd0, ack0, ack1, busy, bcd0, bcd1}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_outputs", {3'd0, ack0, ack1, busy, bcd0, bcd1}, 32'd0);
    end

    // Tie right after reset: requester 0 first, requester 1 ten cycles later.
    transact(1, 1, 8'd42, 8'd7, 8'd42, 8'd7, "tie");

    // Directed single conversions.
    transact(1, 0, 8'd255, 8'd0, 8'd255, 8'd0, "single255");
    transact(1, 0, 8'd0,   8'd0, 8'd0,   8'd0, "single0");
    transact(1, 0, 8'd9,   8'd0, 8'd9,   8'd0, "single9");
    transact(1, 0, 8'd100, 8'd0, 8'd100, 8'd0, "single100");
    transact(0, 1, 8'd0,   8'd250, 8'd0, 8'd250, "single1_250");

    // Operand change during the conversion must be ignored.
    transact(1, 0, 8'd200, 8'd0, 8'd13, 8'd0, "opnd_change");

    // Fairness: both requests held, six acks must alternate every N+2 cycles.
    a = 8'($urandom); b = 8'($urandom);
    bcd_m[0] = to_bcd(int'(a)); bcd_m[1] = to_bcd(int'(b));
    @(negedge clock);
    req0 = 1; req1 = 1; bin0 = a; bin1 = b;
    exp_id = last_m ? 0 : 1;
    cyc = 0; n = 0; prev = 0; collide = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (ack0 && ack1) collide++;
      if (ack0 | ack1) begin
        chk("fair_order", 32'(ack1), 32'(exp_id));
        chk("fair_spacing", 32'(cyc - prev), 32'(N + 2));
        chk("fair_bcd", exp_id == 1 ? 32'(bcd1) : 32'(bcd0), 32'(bcd_m[exp_id]));
        prev = cyc;
        last_m = (exp_id == 1);
        exp_id = 1 - exp_id;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    chk("fair_count", 32'(n), 32'd6);
    chk("fair_collide", 32'(collide), 32'd0);
    @(negedge clock);
    chk("fair_pulse_end", {30'd0, ack1, ack0}, 32'd0);

    // Reset in the 4th SHIFT cycle aborts the conversion.
    @(negedge clock);
    req0 = 1; bin0 = 8'd150;
    @(negedge clock);
    req0 = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_m = 1'b1; bcd_m[0] = 12'h000; bcd_m[1] = 12'h000;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (ack0 | ack1) seen++;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    chk("abort_outputs", {8'd0, busy, bcd0, bcd1}, 32'd0);
    transact(0, 1, 8'd0, 8'd99, 8'd0, 8'd99, "after_abort");

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      transact(mode != 1, mode != 0, 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), "rand");
    end

    // N = 9 sweep over 0..511.
    for (int v = 0; v < 512; v++) begin
      @(negedge clock);
      req9 = 1; bin9 = 9'(v);
      cyc = 0;
      while (!ack9_0 && cyc < 40) begin
        @(negedge clock);
        cyc++;
        if (cyc == 1) req9 = 0;
      end
      ok  = (bcd9_0[11:8] <= 4'd9) && (bcd9_0[7:4] <= 4'd9) && (bcd9_0[3:0] <= 4'd9);
      val = int'(bcd9_0[11:8]) * 100 + int'(bcd9_0[7:4]) * 10 + int'(bcd9_0[3:0]);
      chk("sweep_digits", 32'(ok), 32'd1);
      chk("sweep_value", 32'(val), 32'(v));
    end
    chk("sweep_side1", {19'd0, ack9_1, bcd9_1}, 32'd0);
    chk("sweep_idle", 32'(busy9), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
